// File: rtl/tag_out_pkg.sv
// Shared types and defaults for the outbound tag driver (tag_out).
package tag_out_pkg;

    // Handshake sequencer states; the ST_ prefix keeps them distinct from
    // the SETUP parameter of the same name in the driver.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_WAITDROP = 3'd3,
        ST_RECOVER  = 3'd4
    } tag_out_state_t;

    localparam int TAG_SETUP_DEF   = 5;
    localparam int TAG_MIN_LOW_DEF = 5;
    localparam int TAG_TIMEOUT_DEF = 255;

    // Largest of three cycle counts, used to size the counters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tag_out.sv
// Outbound tag driver: setup delay, interlocked tag/response handshake,
// then a minimum recovery time before the next request is accepted.
// Optional feature macro TAG_OUT_TIMEOUT_EN: when defined, a response
// timeout in ASSERT drops the tag and pulses o_timeout; when undefined the
// driver waits for the response indefinitely and o_timeout is tied low.
module tag_out
    import tag_out_pkg::*;
#(
    parameter int SETUP   = TAG_SETUP_DEF,
    parameter int MIN_LOW = TAG_MIN_LOW_DEF,
    parameter int TIMEOUT = TAG_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    input  logic i_resp,
    output logic o_tag,
    output logic o_busy,
    output logic o_done,
    output logic o_timeout
);

    // One width for every counter: large enough for the longest interval.
    localparam int CNT_W = $clog2(max3(SETUP, MIN_LOW, TIMEOUT)) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] MIN_LOW_LD = CNT_W'(MIN_LOW - 1);

    tag_out_state_t   r_state;
    tag_out_state_t   w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tag;
    logic             w_tag_next;
    logic             r_busy;
    logic             r_done;
    logic             w_done_next;

`ifdef TAG_OUT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] w_tcnt_next;
    logic             r_timeout;
    logic             w_timeout_next;
`endif

    // Next-state, counter and registered-output decode for the handshake.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tag_next   = r_tag;
        w_done_next  = 1'b0;
`ifdef TAG_OUT_TIMEOUT_EN
        w_tcnt_next    = r_tcnt;
        w_timeout_next = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_next = ST_SETUP;
                    w_cnt_next   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end else begin
                    w_tag_next   = 1'b1;
                    w_state_next = ST_ASSERT;
`ifdef TAG_OUT_TIMEOUT_EN
                    w_tcnt_next  = '0;
`endif
                end
            end
            ST_ASSERT: begin
                // A response on the last timeout cycle still wins.
                if (i_resp) begin
                    w_tag_next   = 1'b0;
                    w_state_next = ST_WAITDROP;
                end
`ifdef TAG_OUT_TIMEOUT_EN
                else if (r_tcnt == TIMEOUT_LAST) begin
                    w_tag_next     = 1'b0;
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_RECOVER;
                    w_cnt_next     = MIN_LOW_LD;
                end else begin
                    w_tcnt_next = r_tcnt + CNT_ONE;
                end
`endif
            end
            ST_WAITDROP: begin
                // First low sample completes; later glitches are ignored.
                if (!i_resp) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_RECOVER;
                    w_cnt_next   = MIN_LOW_LD;
                end
            end
            ST_RECOVER: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_tag_next   = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs registered; reset wins over everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tag   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TAG_OUT_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tag   <= w_tag_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= w_done_next;
`ifdef TAG_OUT_TIMEOUT_EN
            r_tcnt    <= w_tcnt_next;
            r_timeout <= w_timeout_next;
`endif
        end
    end

    assign o_tag  = r_tag;
    assign o_busy = r_busy;
    assign o_done = r_done;
`ifdef TAG_OUT_TIMEOUT_EN
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tag_out.sv
// Self-checking bench for tag_out: transaction driver computes expected
// handshake timing from the protocol rules and queues it; a monitor
// measures each busy period on the DUT outputs and compares.
module tb_tag_out;

    localparam int SETUP   = 5;
    localparam int MIN_LOW = 5;
    localparam int TIMEOUT = 20;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;
    logic i_req   = 1'b0;
    logic i_resp  = 1'b0;
    logic o_tag;
    logic o_busy;
    logic o_done;
    logic o_timeout;

    tag_out #(
        .SETUP   (SETUP),
        .MIN_LOW (MIN_LOW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req),
        .i_resp    (i_resp),
        .o_tag     (o_tag),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Edge counter: after posedge k it holds k.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Kinds: 0 normal handshake, 1 timeout, 2 reset mid-ASSERT.
    typedef struct {
        int kind;
        int gap;
        int d;
        int h;
        bit early;
        bit glitch;
        bit held;
    } txn_t;

    // Expected busy period; times are relative to the acceptance edge.
    // fin_kind: 0 none, 1 done, 2 timeout.
    typedef struct {
        int accept;
        int rise;
        int fall;
        int fin;
        int fin_kind;
        int busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   next_idle;
    bit   prev_held = 1'b0;
    bit   mon_en    = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic txn_t mk(input int kind, input int gap, input int d, input int h,
                                input bit early, input bit glitch, input bit held);
        txn_t t;
        t.kind = kind; t.gap = gap; t.d = d; t.h = h;
        t.early = early; t.glitch = glitch; t.held = held;
        return t;
    endfunction

    // Drive one request/response exchange edge by edge and queue its expectation.
    task automatic run_txn(input txn_t t);
        int   a, r, b, rst_e, start;
        bit   rq, rs, rt;
        exp_t e;
        start = next_idle;
        a     = start + (prev_held ? 0 : t.gap);
        r     = a + SETUP + 1 + t.d;
        rst_e = a + SETUP + 2;
        e.accept = a;
        e.rise   = SETUP;
        if (t.kind == 1) begin
            e.fall = SETUP + TIMEOUT; e.fin = SETUP + TIMEOUT; e.fin_kind = 2;
            e.busy_len = SETUP + TIMEOUT + MIN_LOW;
        end else if (t.kind == 2) begin
            e.fall = SETUP + 2; e.fin = -1; e.fin_kind = 0; e.busy_len = SETUP + 2;
        end else begin
            e.fall = r - a; e.fin = r + t.h - a; e.fin_kind = 1;
            e.busy_len = r + t.h - a + MIN_LOW;
        end
        b = a + e.busy_len;
        exp_q.push_back(e);
        $display("txn kind=%0d accept=%0d d=%0d h=%0d early=%0b glitch=%0b held=%0b exp_fall=%0d exp_busy=%0d",
                 t.kind, a, t.d, t.h, t.early, t.glitch, t.held, e.fall, e.busy_len);
        for (int ed = start; ed <= b; ed++) begin
            rq = (ed == a) || (t.held && ed > a);
            rt = (t.kind == 2) && (ed == rst_e);
            rs = 1'b0;
            if (t.kind == 0) begin
                rs = ((ed >= r) && (ed < r + t.h)) ||
                     (t.early && (ed >= start) && (ed < r)) ||
                     (t.glitch && (ed >= r + t.h + 1) && (ed < r + t.h + 3));
            end
            i_req   = rq;
            i_reset = rt;
            i_resp  = rs;
            @(posedge i_clk);
            #1;
        end
        i_reset   = 1'b0;
        i_resp    = 1'b0;
        prev_held = t.held;
        next_idle = b + 1;
    endtask

    // Monitor: measure each busy period and compare against the queue head.
    int   m_start = 0, m_rise = -1, m_fall = -1, m_end = -1, m_kind = 0, m_extra = 0;
    logic p_busy = 1'b0, p_tag = 1'b0;
    exp_t got_e;

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_busy && !p_busy) begin
                m_start = cyc; m_rise = -1; m_fall = -1; m_end = -1; m_kind = 0; m_extra = 0;
            end
            if (o_done && o_timeout) m_extra++;
            if (o_tag && !p_tag) begin
                if (m_rise < 0) m_rise = cyc - m_start; else m_extra++;
            end
            if (!o_tag && p_tag) begin
                if (m_fall < 0) m_fall = cyc - m_start; else m_extra++;
            end
            if (o_done || o_timeout) begin
                if (m_end >= 0) m_extra++;
                m_end  = cyc - m_start;
                m_kind = o_done ? 1 : 2;
            end
            if (!o_busy && p_busy) begin
                if (exp_q.size() == 0) begin
                    check("queue_has_expectation", exp_q.size(), 1);
                end else begin
                    got_e = exp_q.pop_front();
                    check("accept_edge", m_start, got_e.accept);
                    check("tag_rise", m_rise, got_e.rise);
                    check("tag_fall", m_fall, got_e.fall);
                    check("finish_edge", m_end, got_e.fin);
                    check("finish_kind", m_kind, got_e.fin_kind);
                    check("busy_len", cyc - m_start, got_e.busy_len);
                    check("extra_events", m_extra, 0);
                    $display("obs accept=%0d rise=%0d fall=%0d fin=%0d kind=%0d busy=%0d",
                             m_start, m_rise, m_fall, m_end, m_kind, cyc - m_start);
                end
            end
            p_busy = o_busy;
            p_tag  = o_tag;
        end
    end

    initial begin
        txn_t t;
        int   sel, d;

        // Reset held for two edges with request and response both high.
        i_reset = 1'b1; i_req = 1'b1; i_resp = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clk);
            #1;
            check("rst_tag", o_tag, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_timeout", o_timeout, 0);
            $display("reset edge %0d: tag=%0b busy=%0b done=%0b timeout=%0b",
                     cyc, o_tag, o_busy, o_done, o_timeout);
        end
        i_reset   = 1'b0;
        i_resp    = 1'b0;
        next_idle = cyc + 1;
        mon_en    = 1'b1;

        // Directed: basic handshake (response at edge 8, drop at edge 12).
        run_txn(mk(0, 0, 2, 4, 1'b0, 1'b0, 1'b0));
        // Request held high across a whole handshake; re-accepted immediately.
        run_txn(mk(0, 0, 2, 4, 1'b0, 1'b0, 1'b1));
        run_txn(mk(0, 2, 2, 4, 1'b0, 1'b0, 1'b0));
        // Response already high before acceptance: one-cycle tag.
        run_txn(mk(0, 1, 0, 3, 1'b1, 1'b0, 1'b0));
        // Response on the final cycle before timeout.
        run_txn(mk(0, 0, TIMEOUT - 1, 1, 1'b0, 1'b0, 1'b0));
`ifdef TAG_OUT_TIMEOUT_EN
        run_txn(mk(1, 1, 0, 1, 1'b0, 1'b0, 1'b0));
`else
        run_txn(mk(0, 1, 1000, 2, 1'b0, 1'b0, 1'b0));
`endif
        // Reset in ASSERT, then a fresh request runs the full setup.
        run_txn(mk(2, 0, 0, 1, 1'b0, 1'b0, 1'b0));
        run_txn(mk(0, 0, 1, 1, 1'b0, 1'b0, 1'b0));
        // Response glitch during recovery must be ignored.
        run_txn(mk(0, 0, 3, 2, 1'b0, 1'b1, 1'b0));

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 9);
            d   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, TIMEOUT - 1);
            t   = mk(0, $urandom_range(0, 3), d, $urandom_range(1, 4),
                     (d == 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0);
`ifdef TAG_OUT_TIMEOUT_EN
            if (sel == 7) t.kind = 1;
`endif
            if (sel == 8) t.kind = 2;
            run_txn(t);
        end
        i_req = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge i_clk);
        #1;
        check("drain_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
